// File: rtl/rob_flush_ctrl.sv
// Mispredict flush controller: picks the oldest branch flush from int0/int1, issues it to ROB and fetch.
// Latency: request at cycle t -> flush_valid/redirect_valid at t+1; dispatch stall held until ROB recovery completes.
// Backpressure: none; requests not older than the one in flight are dropped, since those ops are already squashed.
module rob_flush_ctrl #(
    parameter int ROB_WIDTH = 4,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br0_valid,
    input  logic [ROB_WIDTH:0]   br0_robid,
    input  logic [PC_WIDTH-1:0]  br0_target,
    input  logic                 br1_valid,
    input  logic [ROB_WIDTH:0]   br1_robid,
    input  logic [PC_WIDTH-1:0]  br1_target,
    input  logic [ROB_WIDTH:0]   rob_tail,
    input  logic [1:0]           rob_state,
    output logic                 flush_valid,
    output logic [ROB_WIDTH:0]   flush_robid,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 dispatch_stall,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   seen_busy_q;
    logic [ROB_WIDTH:0]     req_robid_q;
    logic [PC_WIDTH-1:0]    req_target_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;

    logic [ROB_WIDTH:0]     age0;
    logic [ROB_WIDTH:0]     age1;
    logic [ROB_WIDTH:0]     age_req;
    logic                   pick1;
    logic                   win_valid;
    logic [ROB_WIDTH:0]     win_robid;
    logic [PC_WIDTH-1:0]    win_target;
    logic [ROB_WIDTH:0]     win_age;
    logic                   win_older;
    logic                   rob_idle;
    logic                   recover_done;

    // Ages are distances from the retire pointer; modular subtraction handles the wrap bit.
    assign age0    = br0_robid - rob_tail;
    assign age1    = br1_robid - rob_tail;
    assign age_req = req_robid_q - rob_tail;

    // br1 wins only when strictly older; ties go to br0.
    assign pick1      = br1_valid & (~br0_valid | (age1 < age0));
    assign win_valid  = br0_valid | br1_valid;
    assign win_robid  = pick1 ? br1_robid  : br0_robid;
    assign win_target = pick1 ? br1_target : br0_target;
    assign win_age    = pick1 ? age1       : age0;
    assign win_older  = win_valid & (win_age < age_req);

    assign rob_idle     = (rob_state == 2'd0);
    assign recover_done = (state_q == RECOVER) & rob_idle & seen_busy_q;

    // Saturating increment of the issued-flush counter.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Flush sequencing: latch winner, issue for one cycle, then wait for the ROB walk to finish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            seen_busy_q  <= 1'b0;
            req_robid_q  <= '0;
            req_target_q <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        req_robid_q  <= win_robid;
                        req_target_q <= win_target;
                        cnt_q        <= cnt_d;
                        state_q      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (win_older) begin
                        req_robid_q  <= win_robid;
                        req_target_q <= win_target;
                        cnt_q        <= cnt_d;
                    end else begin
                        seen_busy_q <= 1'b0;
                        state_q     <= RECOVER;
                    end
                end
                RECOVER: begin
                    // An older mispredict restarts the flush; the ROB goes back to rollback.
                    if (win_older) begin
                        req_robid_q  <= win_robid;
                        req_target_q <= win_target;
                        cnt_q        <= cnt_d;
                        state_q      <= FLUSH;
                    end else if (recover_done) begin
                        state_q <= IDLE;
                    end else if (!rob_idle) begin
                        seen_busy_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state; stall releases in the cycle the ROB is seen idle again.
    assign flush_valid    = (state_q == FLUSH);
    assign redirect_valid = (state_q == FLUSH);
    assign busy           = (state_q != IDLE);
    assign dispatch_stall = (state_q == FLUSH) | ((state_q == RECOVER) & ~recover_done);
    assign flush_robid    = req_robid_q;
    assign redirect_pc    = req_target_q;
    assign flush_count    = cnt_q;

endmodule

// File: tb/tb_rob_flush_ctrl.sv
module tb_rob_flush_ctrl;

    localparam int RW = 4;
    localparam int PW = 32;
    localparam int CW = 4;   // narrow counter so saturation is reachable
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          br0_valid, br1_valid;
    logic [RW:0]   br0_robid, br1_robid, rob_tail;
    logic [PW-1:0] br0_target, br1_target;
    logic [1:0]    rob_state;
    logic          flush_valid, redirect_valid, dispatch_stall, busy;
    logic [RW:0]   flush_robid;
    logic [PW-1:0] redirect_pc;
    logic [CW-1:0] flush_count;

    always #5 clk = ~clk;

    rob_flush_ctrl #(.ROB_WIDTH(RW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .br0_valid(br0_valid), .br0_robid(br0_robid), .br0_target(br0_target),
        .br1_valid(br1_valid), .br1_robid(br1_robid), .br1_target(br1_target),
        .rob_tail(rob_tail), .rob_state(rob_state),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dispatch_stall(dispatch_stall), .busy(busy), .flush_count(flush_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic fv, input logic [RW:0] rid,
                           input logic [PW-1:0] pc, input logic st, input logic bz,
                           input logic [CW-1:0] cnt);
        chk({tag, ".flush_valid"},    64'(flush_valid),    64'(fv));
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(fv));
        chk({tag, ".flush_robid"},    64'(flush_robid),    64'(rid));
        chk({tag, ".redirect_pc"},    64'(redirect_pc),    64'(pc));
        chk({tag, ".dispatch_stall"}, 64'(dispatch_stall), 64'(st));
        chk({tag, ".busy"},           64'(busy),           64'(bz));
        chk({tag, ".flush_count"},    64'(flush_count),    64'(cnt));
    endtask

    task automatic drive(input logic b0v, input logic [RW:0] b0id, input logic [PW-1:0] b0t,
                         input logic b1v, input logic [RW:0] b1id, input logic [PW-1:0] b1t,
                         input logic [RW:0] tl, input logic [1:0] rs);
        br0_valid = b0v; br0_robid = b0id; br0_target = b0t;
        br1_valid = b1v; br1_robid = b1id; br1_target = b1t;
        rob_tail = tl; rob_state = rs;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          b0v;  logic [RW:0] b0id; logic [PW-1:0] b0t;
        logic          b1v;  logic [RW:0] b1id; logic [PW-1:0] b1t;
        logic [RW:0]   tail; logic [1:0]  rs;
        logic          fv;   logic [RW:0] rid;  logic [PW-1:0] pc;
        logic          st;   logic        bz;   logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic b0v, input int b0id, input int b0t,
                                input logic b1v, input int b1id, input int b1t,
                                input int tl, input int rs,
                                input logic fv, input int rid, input int pc,
                                input logic st, input logic bz, input int cnt);
        vec_t v;
        v.b0v = b0v; v.b0id = b0id[RW:0]; v.b0t = b0t[PW-1:0];
        v.b1v = b1v; v.b1id = b1id[RW:0]; v.b1t = b1t[PW-1:0];
        v.tail = tl[RW:0]; v.rs = rs[1:0];
        v.fv = fv; v.rid = rid[RW:0]; v.pc = pc[PW-1:0];
        v.st = st; v.bz = bz; v.cnt = cnt[CW-1:0];
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Tracks "a flush is being issued this cycle", "waiting for ROB recovery",
    // and whether the ROB has been observed busy since recovery began.
    bit          m_issuing, m_recovering, m_rob_seen_busy;
    int          m_robid, m_cnt;
    logic [PW-1:0] m_pc;

    function automatic int age_of(input int id, input int tl);
        return ((id - tl) % 32 + 32) % 32;
    endfunction

    task automatic model_reset();
        m_issuing = 0; m_recovering = 0; m_rob_seen_busy = 0;
        m_robid = 0; m_pc = '0; m_cnt = 0;
    endtask

    task automatic model_check(input string tag);
        bit exp_stall;
        exp_stall = m_issuing || (m_recovering && !(rob_state == 2'd0 && m_rob_seen_busy));
        chk_all(tag, m_issuing, m_robid[RW:0], m_pc, exp_stall,
                m_issuing || m_recovering, m_cnt[CW-1:0]);
    endtask

    task automatic model_step();
        int cand_id;
        logic [PW-1:0] cand_pc;
        int tl;
        bit have;
        tl = int'(rob_tail);
        have = 0; cand_id = 0; cand_pc = '0;
        if (br0_valid) begin have = 1; cand_id = int'(br0_robid); cand_pc = br0_target; end
        if (br1_valid && (!have || age_of(int'(br1_robid), tl) < age_of(cand_id, tl))) begin
            have = 1; cand_id = int'(br1_robid); cand_pc = br1_target;
        end
        if (!m_issuing && !m_recovering) begin
            if (have) begin
                m_robid = cand_id; m_pc = cand_pc; m_issuing = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (have && age_of(cand_id, tl) < age_of(m_robid, tl)) begin
            m_robid = cand_id; m_pc = cand_pc; m_issuing = 1; m_recovering = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (m_issuing) begin
            m_issuing = 0; m_recovering = 1; m_rob_seen_busy = 0;
        end else if (rob_state == 2'd0 && m_rob_seen_busy) begin
            m_recovering = 0;
        end else if (rob_state != 2'd0) begin
            m_rob_seen_busy = 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, '0, 0, '0, '0, '0, 2'd0);
        #1;
        chk_all("reset", 0, '0, '0, 0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        //          b0v id  tgt     b1v id  tgt     tail rs  fv rid pc     st bz cnt
        // single request, ROB goes rollback -> walk -> idle
        tbl.push_back(mk(1, 5, 'h100,  0, 0, 0,       0, 0,  0, 0,  0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  1, 5,  'h100, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 1,  0, 5,  'h100, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 2,  0, 5,  'h100, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 5,  'h100, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 5,  'h100, 0, 0, 1));
        // simultaneous: older br1 wins
        tbl.push_back(mk(1, 9, 'h300,  1, 6, 'h200,   3, 0,  0, 5,  'h100, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 0,  1, 6,  'h200, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 1,  0, 6,  'h200, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 0,  0, 6,  'h200, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 0,  0, 6,  'h200, 0, 0, 2));
        // equal robids: br0 wins; rob_state 3 counts as busy
        tbl.push_back(mk(1, 12, 'h400, 1, 12, 'h500,  3, 0,  0, 6,  'h200, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 3,  1, 12, 'h400, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 3,  0, 12, 'h400, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 0,  0, 12, 'h400, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       3, 0,  0, 12, 'h400, 0, 0, 3));
        // wrap-around: tail 30, robid 31 older than robid 1
        tbl.push_back(mk(1, 1, 'h600,  1, 31, 'h700,  30, 0, 0, 12, 'h400, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       30, 0, 1, 31, 'h700, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       30, 1, 0, 31, 'h700, 1, 1, 4));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       30, 0, 0, 31, 'h700, 0, 1, 4));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       30, 0, 0, 31, 'h700, 0, 0, 4));
        // older request during RECOVER re-flushes; younger one is dropped
        tbl.push_back(mk(1, 10, 'h800, 0, 0, 0,       0, 0,  0, 31, 'h700, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  1, 10, 'h800, 1, 1, 5));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 2,  0, 10, 'h800, 1, 1, 5));
        tbl.push_back(mk(0, 0, 0,      1, 7, 'h900,   0, 2,  0, 10, 'h800, 1, 1, 5));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 2,  1, 7,  'h900, 1, 1, 6));
        tbl.push_back(mk(1, 12, 'hA00, 0, 0, 0,       0, 2,  0, 7,  'h900, 1, 1, 6));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 2,  0, 7,  'h900, 1, 1, 6));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 7,  'h900, 0, 1, 6));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 7,  'h900, 0, 0, 6));
        // back-to-back in FLUSH: flush held two cycles
        tbl.push_back(mk(1, 8, 'hB00,  0, 0, 0,       0, 0,  0, 7,  'h900, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0,      1, 4, 'hC00,   0, 0,  1, 8,  'hB00, 1, 1, 7));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  1, 4,  'hC00, 1, 1, 8));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 1,  0, 4,  'hC00, 1, 1, 8));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 4,  'hC00, 0, 1, 8));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 4,  'hC00, 0, 0, 8));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].b0v, tbl[i].b0id, tbl[i].b0t, tbl[i].b1v, tbl[i].b1id, tbl[i].b1t,
                  tbl[i].tail, tbl[i].rs);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].fv, tbl[i].rid, tbl[i].pc,
                    tbl[i].st, tbl[i].bz, tbl[i].cnt);
        end

        // async reset asserted mid-cycle while in RECOVER
        @(negedge clk); drive(1, 5'd3, 32'h1234, 0, '0, '0, '0, 2'd0);
        @(negedge clk); drive(0, '0, '0, 0, '0, '0, '0, 2'd0);
        @(negedge clk); drive(0, '0, '0, 0, '0, '0, '0, 2'd1);
        #1;
        chk("pre_reset.busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 0, '0, '0, 0, 0, '0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); drive(0, '0, '0, 0, '0, '0, '0, 2'd0);
        #1;
        chk_all("post_reset", 0, '0, '0, 0, 0, '0);
        @(negedge clk); drive(0, '0, '0, 1, 5'd2, 32'h55, '0, 2'd0);
        @(negedge clk); drive(0, '0, '0, 0, '0, '0, '0, 2'd0);
        #1;
        chk_all("post_reset_flush", 1, 5'd2, 32'h55, 1, 1, 4'd1);

        // randomized run against the reference model
        @(negedge clk); reset = 1'b1;
        drive(0, '0, '0, 0, '0, '0, '0, 2'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [RW:0] tl;
            logic [1:0]  rs;
            @(negedge clk);
            tl = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(0, 31)) : rob_tail;
            rs = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            drive($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), PW'($urandom),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), PW'($urandom),
                  tl, rs);
            #1;
            model_check($sformatf("rand%0d", c));
            @(posedge clk);
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
